regfile_dump: RTL and testbench

Debug readout engine that sweeps every location of the CPU register file and streams each `{address, data}` pair out over a valid/ready handshake. It sits beside `register_file` and drives one of its read-address ports (muxed in by the parent while `busy` is high). It is the reader counterpart to the datapath's write port, used by the debug/scan path to dump architectural state without stopping the clock.

---
 rtl/regfile_dump_pkg.sv | 12 +
 rtl/regfile_dump.sv | 123 ++++++++++++
 tb/tb_regfile_dump.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump engine.
package regfile_dump_pkg;

  // Sweep sequencer states: LOAD samples one location, SEND offers it downstream.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug readout engine: walks every register-file location and streams
// {address, data} pairs out over a valid/ready handshake.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with out_addr
// and out_data frozen, until that transfer or an abort. out_ready may be high
// before out_valid; it has no effect while out_valid is low.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int Nloc  = 32,
  parameter int Dbits = 32,
  localparam int Abits = (Nloc > 1) ? $clog2(Nloc) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [Abits-1:0]  rf_addr,
  input  logic [Dbits-1:0]  rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Abits-1:0]  out_addr,
  output logic [Dbits-1:0]  out_data,
  output dump_state_t       dbg_state
);

  // Terminal count; comparing against it (not wrapping) handles any Nloc.
  localparam logic [Abits-1:0] LastAddr = Abits'(Nloc - 1);

  dump_state_t      r_state;
  logic [Abits-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_out_valid;
  logic [Abits-1:0] r_out_addr;
  logic [Dbits-1:0] r_out_data;

  logic             w_handshake;
  logic             w_last;

  assign w_handshake = r_out_valid & out_ready;
  assign w_last      = (r_count == LastAddr);

  // Sequencer, location counter, output word and status flags all advance together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // abort is meaningless here, so start always wins.
          if (start) begin
            r_state <= LOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end

        LOAD: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            // Snapshot of the location as it stands at this edge.
            r_out_addr  <= r_count;
            r_out_data  <= rf_data;
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            // A word accepted on this same edge is simply the last one emitted.
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end else if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + Abits'(1);
              r_state <= LOAD;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rf_addr   = r_count;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file, directed dump scenarios,
// and a monitor that checks every accepted word against an expected queue.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int NLOC  = 32;
  localparam int DBITS = 32;
  localparam int AW    = 5;
  localparam int W     = AW + DBITS;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [AW-1:0]     rf_addr;
  logic [DBITS-1:0]  rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_addr;
  logic [DBITS-1:0]  out_data;
  dump_state_t       dbg_state;

  logic [DBITS-1:0]  rf_mem [NLOC];
  logic [W-1:0]      exp_q [$];

  int n_tests    = 0;
  int n_fail     = 0;
  int done_count = 0;
  int pop_count  = 0;

  regfile_dump #(.Nloc(NLOC), .Dbits(DBITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // Combinational register-file read port.
  assign rf_data = rf_mem[rf_addr];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DBITS-1:0] preload(input int i);
    return (i == 0) ? 32'h0 : (32'hA000_0000 + i);
  endfunction

  task automatic fill_rf();
    for (int i = 0; i < NLOC; i++) rf_mem[i] = preload(i);
  endtask

  // Push the 32 expected words; ov_addr < 0 means no override.
  task automatic push_dump(input int ov_addr, input logic [DBITS-1:0] ov_data);
    for (int i = 0; i < NLOC; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      exp_q.push_back({a, (i == ov_addr) ? ov_data : preload(i)});
    end
  endtask

  // Step until out_valid shows the given address; expiry counts as a failure.
  task automatic wait_word(input int addr);
    int k;
    k = 0;
    forever begin
      @(negedge clock);
      start = 1'b0;
      k++;
      if (out_valid && (out_addr == AW'(addr))) return;
      if (k > 300) begin
        n_tests++; n_fail++;
        $display("FAIL wait_word_timeout: addr %0d never offered", addr);
        return;
      end
    end
  endtask

  // Count negedges until done is seen; expiry counts as a failure.
  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clock);
      #1;
      cyc++;
      if (done) return;
      if (cyc > 300) begin
        n_tests++; n_fail++;
        $display("FAIL wait_done_timeout: no done after %0d cycles", cyc);
        return;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          stall_prev = 1'b0;
  logic          abort_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DBITS-1:0] prev_data;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (done) done_count++;
        if (stall_prev && !abort_prev) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_addr", out_addr, prev_addr);
          check("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_word: addr %0d data %0h with empty queue", out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            check("word_addr", out_addr, e[W-1:DBITS]);
            check("word_data", out_data, e[DBITS-1:0]);
            pop_count++;
          end
        end
        stall_prev = out_valid && !out_ready;
        abort_prev = abort;
        prev_addr  = out_addr;
        prev_data  = out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int d0;
    int p0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    fill_rf();
    repeat (2) @(negedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_busy", busy, 1'b0);

    // Full dump, ready always high, with latency and done timing.
    d0 = done_count; p0 = pop_count;
    push_dump(-1, '0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    check("lat_busy", busy, 1'b1);
    check("lat_state", dbg_state, LOAD);
    check("lat_valid_c1", out_valid, 1'b0);
    @(negedge clock);
    #1;
    check("lat_valid_c2", out_valid, 1'b1);
    check("lat_addr_c2", out_addr, 0);
    wait_done(c);
    check("done_cycle", c + 2, 65);
    @(negedge clock);
    #3;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", dbg_state, IDLE);
    check("full_words", pop_count - p0, 32);
    check("full_done", done_count - d0, 1);
    check("full_queue_empty", exp_q.size(), 0);

    // Backpressure on word 3 for five cycles.
    d0 = done_count;
    push_dump(-1, '0);
    start = 1'b1;
    wait_word(3);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_addr", out_addr, 3);
      check("bp_data", out_data, 32'hA000_0003);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    #1;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_rfaddr", rf_addr, 4);
    wait_done(c);
    @(negedge clock);
    check("bp_done", done_count - d0, 1);
    check("bp_queue_empty", exp_q.size(), 0);

    // Abort during SEND of word 10 (same-cycle handshake still consumes it).
    d0 = done_count;
    push_dump(-1, '0);
    start = 1'b1;
    wait_word(10);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_state", dbg_state, IDLE);
    repeat (4) @(negedge clock);
    check("abort_no_done", done_count - d0, 0);
    check("abort_left", exp_q.size(), 21);
    exp_q.delete();
    push_dump(-1, '0);
    start = 1'b1;
    wait_done(c);
    @(negedge clock);
    check("restart_done", done_count - d0, 1);
    check("restart_queue_empty", exp_q.size(), 0);

    // Concurrent writes while word 5 is offered.
    push_dump(20, 32'hDEAD_BEEF);
    start = 1'b1;
    wait_word(5);
    rf_mem[20] = 32'hDEAD_BEEF;
    rf_mem[2]  = 32'h1234_5678;
    wait_done(c);
    @(negedge clock);
    check("cw_queue_empty", exp_q.size(), 0);
    fill_rf();

    // Start held high throughout: one dump, then a fresh LOAD after IDLE.
    d0 = done_count;
    push_dump(-1, '0);
    @(negedge clock);
    start = 1'b1;
    wait_done(c);
    check("held_done_cycle", c, 65);
    @(negedge clock);
    #1;
    check("held_idle", dbg_state, IDLE);
    check("held_idle_busy", busy, 1'b0);
    @(negedge clock);
    #1;
    check("held_reload", dbg_state, LOAD);
    check("held_queue_empty", exp_q.size(), 0);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    #1;
    check("held_abort_state", dbg_state, IDLE);
    check("held_one_dump", done_count - d0, 1);

    // Asynchronous reset in the middle of word 7.
    push_dump(-1, '0);
    start = 1'b1;
    wait_word(7);
    #3;
    reset = 1'b1;
    #1;
    check("areset_busy", busy, 1'b0);
    check("areset_valid", out_valid, 1'b0);
    check("areset_out_addr", out_addr, 0);
    check("areset_out_data", out_data, 0);
    check("areset_rf_addr", rf_addr, 0);
    check("areset_state", dbg_state, IDLE);
    @(negedge clock);
    #3;
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clock);
    #1;
    check("post_reset_idle", dbg_state, IDLE);
    check("post_reset_valid", out_valid, 1'b0);
    check("total_done", done_count, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
